// File: rtl/acc_ctrl_pkg.sv
// Shared types and default sizing for the accumulator write scheduler.
package acc_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } acc_state_t;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefBurstLen  = 4;

endpackage

// File: rtl/acc_write_scheduler_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_select #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic              any,
    output logic [NumReq-1:0] onehot,
    output logic [IdxW-1:0]   idx
);

    logic [IdxW-1:0] cand;

    // Scan from ptr upward and take the first active requester.
    always_comb begin
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = IdxW'((32'(ptr) + k) % NumReq);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/acc_write_scheduler.sv
// Arbitrates PE-column bursts into the shared ACC FIFO and drains the FIFO
// through a single-register valid/ready output stage.
module acc_write_scheduler
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned NumReq    = DefNumReq,
    parameter int unsigned BurstLen  = DefBurstLen
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic [NumReq-1:0]           Req,
    input  logic [NumReq*DataWidth-1:0] ReqData,
    output logic [NumReq-1:0]           Grant,
    output logic [NumReq-1:0]           BurstDone,
    input  logic                        Full,
    input  logic                        Empty,
    output logic                        Push,
    output logic [DataWidth-1:0]        PushData,
    output logic                        Pop,
    input  logic [DataWidth-1:0]        FifoData,
    output logic                        OutValid,
    output logic [DataWidth-1:0]        OutData,
    input  logic                        OutReady
);

    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned BeatW = $clog2(BurstLen + 1);

    acc_state_t        state;
    acc_state_t        state_nxt;
    logic [IdxW-1:0]   owner;
    logic [NumReq-1:0] owner_oh;
    logic [IdxW-1:0]   rr_ptr;
    logic [BeatW-1:0]  beat;

    logic              sel_any;
    logic [NumReq-1:0] sel_onehot;
    logic [IdxW-1:0]   sel_idx;

    logic              owner_req;
    logic              last_beat;
    logic              burst_end;

    rr_select #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_select (
        .req    (Req),
        .ptr    (rr_ptr),
        .any    (sel_any),
        .onehot (sel_onehot),
        .idx    (sel_idx)
    );

    assign owner_req = |(Req & owner_oh);
    assign last_beat = (beat == BeatW'(BurstLen - 1));
    assign burst_end = Push & last_beat;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: claim a requester from IDLE, return after the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_any)   state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the owner's word is accepted whenever it is offered and
    // the FIFO has room; reset forces these low even before the first edge.
    always_comb begin
        Push  = (state == BURST) & owner_req & ~Full & ~aclr;
        Grant = Push ? owner_oh : '0;
    end

    // Ownership, beat counting, round-robin pointer and completion pulse.
    always_ff @(posedge clk) begin
        if (aclr) begin
            owner     <= '0;
            owner_oh  <= '0;
            rr_ptr    <= '0;
            beat      <= '0;
            BurstDone <= '0;
        end else begin
            BurstDone <= burst_end ? owner_oh : '0;
            if (state == IDLE && sel_any) begin
                owner    <= sel_idx;
                owner_oh <= sel_onehot;
            end
            if (Push) begin
                if (last_beat) begin
                    beat   <= '0;
                    rr_ptr <= (owner == IdxW'(NumReq - 1)) ? '0 : owner + IdxW'(1);
                end else begin
                    beat <= beat + BeatW'(1);
                end
            end
        end
    end

    // Steer the owner's data slice onto the FIFO write bus.
    always_comb begin
        PushData = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (owner == IdxW'(i)) begin
                PushData = ReqData[i*DataWidth +: DataWidth];
            end
        end
    end

    // Pop whenever the output register is free or being consumed this cycle.
    always_comb begin
        Pop = ~Empty & (~OutValid | OutReady) & ~aclr;
    end

    // Output register: load on pop, clear valid once consumed, else hold.
    always_ff @(posedge clk) begin
        if (aclr) begin
            OutValid <= 1'b0;
            OutData  <= '0;
        end else if (Pop) begin
            OutValid <= 1'b1;
            OutData  <= FifoData;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule
